mold_msg_splitter: RTL and testbench

- Consumes the MoldUDP64 payload stream after header strip, 8 bytes per beat, with a thermometer byte-enable.
- Walks the message blocks: 2-byte big-endian length field, then that many message bytes, repeated until the end of the packet.
- Tags every valid byte lane as LEN_HI, LEN_LO or DATA, marks message ends, and counts completed messages.
- Sits directly downstream of the thermometer ones-counter; instantiates cnt_ones_thermo to get the per-beat valid byte count.

---
 rtl/mold_msg_splitter_if.sv | 36 +++
 rtl/mold_msg_splitter.sv | 227 ++++++++++++++++++++++
 tb/tb_mold_msg_splitter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mold_msg_splitter_if.sv
// Beat-stream bundle for the MoldUDP64 message splitter: the payload beat in,
// the per-lane tagged beat and message bookkeeping out.
interface mold_msg_splitter_if #(
    parameter int D_W   = 8,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
);
    logic               valid_i;
    logic               start_i;
    logic               last_i;
    logic [8*D_W-1:0]   data_i;
    logic [D_W-1:0]     keep_i;

    logic               valid_o;
    logic [8*D_W-1:0]   data_o;
    logic [D_W-1:0]     keep_o;
    logic [2*D_W-1:0]   lane_type_o;
    logic [D_W-1:0]     eom_o;
    logic               len_v_o;
    logic [LEN_W-1:0]   len_o;
    logic               cnt_v_o;
    logic [CNT_W-1:0]   msg_cnt_o;
    logic               err_o;

    modport master (
        output valid_i, start_i, last_i, data_i, keep_i,
        input  valid_o, data_o, keep_o, lane_type_o, eom_o,
               len_v_o, len_o, cnt_v_o, msg_cnt_o, err_o
    );

    modport slave (
        input  valid_i, start_i, last_i, data_i, keep_i,
        output valid_o, data_o, keep_o, lane_type_o, eom_o,
               len_v_o, len_o, cnt_v_o, msg_cnt_o, err_o
    );
endinterface

// File: rtl/mold_msg_splitter.sv
// MoldUDP64 message splitter: walks 2-byte length fields and message bodies
// across byte lanes and beats, tagging each lane and counting finished messages.
module cnt_ones_thermo #(
    parameter int D_W  = 8,
    parameter int D_LW = 4
) (
    input  logic [D_W-1:0]  thermo_i,
    output logic [D_LW-1:0] cnt_o
);
    // A thermometer code's population equals the position of its top set bit plus one.
    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < D_W; k++) begin
            if (thermo_i[k]) begin
                cnt_o = D_LW'(k + 1);
            end
        end
    end
endmodule

module mold_msg_splitter #(
    parameter int D_W   = 8,
    parameter int D_LW  = 4,
    parameter int LEN_W = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               nreset,
    mold_msg_splitter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_LEN_HI = 2'd0,
        ST_LEN_LO = 2'd1,
        ST_DATA   = 2'd2
    } state_e;

    localparam logic [1:0] TYPE_LEN_HI = 2'd1;
    localparam logic [1:0] TYPE_LEN_LO = 2'd2;
    localparam logic [1:0] TYPE_DATA   = 2'd3;
    localparam logic [D_W:0] ONE_EXT   = (D_W + 1)'(1);

    logic [D_LW-1:0] byteCnt;

    cnt_ones_thermo #(.D_W(D_W), .D_LW(D_LW)) u_cnt_ones_thermo (
        .thermo_i (bus.keep_i),
        .cnt_o    (byteCnt)
    );

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        hi_q, hi_d;
    logic              valid_q, valid_d;
    logic [8*D_W-1:0]  data_q, data_d;
    logic [D_W-1:0]    keep_q, keep_d;
    logic [2*D_W-1:0]  laneType_q, laneType_d;
    logic [D_W-1:0]    eom_q, eom_d;
    logic              lenV_q, lenV_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              cntV_q, cntV_d;
    logic [CNT_W-1:0]  msgCnt_q, msgCnt_d;
    logic              err_q, err_d;

    state_e            walkState;
    logic [LEN_W-1:0]  walkRem;
    logic [7:0]        walkHi;
    logic [7:0]        curByte;
    logic [LEN_W-1:0]  fieldLen;
    logic [CNT_W-1:0]  walkCnt;
    logic              walkErr;
    logic [LEN_W-1:0]  walkLen;
    logic              walkLenV;
    logic [2*D_W-1:0]  walkType;
    logic [D_W-1:0]    walkEom;

    // The lane chain: a packet start rewinds to a fresh length field before
    // lane 0, then each valid lane advances the parser exactly one byte.
    always_comb begin
        walkState = bus.start_i ? ST_LEN_HI : state_q;
        walkRem   = bus.start_i ? '0 : rem_q;
        walkHi    = bus.start_i ? '0 : hi_q;
        walkCnt   = bus.start_i ? '0 : msgCnt_q;
        walkErr   = bus.start_i ? 1'b0 : err_q;
        walkLen   = len_q;
        walkLenV  = 1'b0;
        walkType  = '0;
        walkEom   = '0;
        curByte   = '0;
        fieldLen  = '0;
        for (int k = 0; k < D_W; k++) begin
            if (k < int'(byteCnt)) begin
                curByte = bus.data_i[8*k +: 8];
                case (walkState)
                    ST_LEN_HI: begin
                        walkType[2*k +: 2] = TYPE_LEN_HI;
                        walkHi             = curByte;
                        walkState          = ST_LEN_LO;
                    end
                    ST_LEN_LO: begin
                        walkType[2*k +: 2] = TYPE_LEN_LO;
                        fieldLen           = LEN_W'({walkHi, curByte});
                        walkLen            = fieldLen;
                        walkLenV           = 1'b1;
                        if (fieldLen == '0) begin
                            walkEom[k] = 1'b1;
                            walkCnt    = walkCnt + CNT_W'(1);
                            walkState  = ST_LEN_HI;
                        end else begin
                            walkRem    = fieldLen;
                            walkState  = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        walkType[2*k +: 2] = TYPE_DATA;
                        walkRem            = walkRem - LEN_W'(1);
                        if (walkRem == '0) begin
                            walkEom[k] = 1'b1;
                            walkCnt    = walkCnt + CNT_W'(1);
                            walkState  = ST_LEN_HI;
                        end
                    end
                    default: begin
                        walkState = ST_LEN_HI;
                    end
                endcase
            end
        end
        // Ending anywhere but a message boundary means the packet was cut short.
        if (bus.last_i) begin
            if (walkState != ST_LEN_HI) begin
                walkErr = 1'b1;
            end
            walkState = ST_LEN_HI;
            walkRem   = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        hi_d       = hi_q;
        data_d     = data_q;
        keep_d     = keep_q;
        len_d      = len_q;
        msgCnt_d   = msgCnt_q;
        err_d      = err_q;
        valid_d    = bus.valid_i;
        laneType_d = '0;
        eom_d      = '0;
        lenV_d     = 1'b0;
        cntV_d     = 1'b0;
        if (bus.valid_i) begin
            state_d    = walkState;
            rem_d      = walkRem;
            hi_d       = walkHi;
            data_d     = bus.data_i;
            keep_d     = bus.keep_i;
            len_d      = walkLen;
            msgCnt_d   = walkCnt;
            err_d      = walkErr;
            laneType_d = walkType;
            eom_d      = walkEom;
            lenV_d     = walkLenV;
            cntV_d     = bus.last_i;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_LEN_HI;
            rem_q      <= '0;
            hi_q       <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            laneType_q <= '0;
            eom_q      <= '0;
            lenV_q     <= 1'b0;
            len_q      <= '0;
            cntV_q     <= 1'b0;
            msgCnt_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            hi_q       <= hi_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            laneType_q <= laneType_d;
            eom_q      <= eom_d;
            lenV_q     <= lenV_d;
            len_q      <= len_d;
            cntV_q     <= cntV_d;
            msgCnt_q   <= msgCnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_q;
    assign bus.keep_o      = keep_q;
    assign bus.lane_type_o = laneType_q;
    assign bus.eom_o       = eom_q;
    assign bus.len_v_o     = lenV_q;
    assign bus.len_o       = len_q;
    assign bus.cnt_v_o     = cntV_q;
    assign bus.msg_cnt_o   = msgCnt_q;
    assign bus.err_o       = err_q;

    // Types 2 and 3 are exactly those with the upper type bit set.
    logic [D_W-1:0] eomTypeBad;
    always_comb begin
        eomTypeBad = '0;
        for (int k = 0; k < D_W; k++) begin
            eomTypeBad[k] = eom_q[k] & ~laneType_q[2*k+1];
        end
    end

    keepThermo: assume property (@(posedge clk) disable iff (!nreset)
        bus.valid_i |-> (bus.keep_i != '0) && $onehot({1'b0, bus.keep_i} + ONE_EXT));

    eomWithinKeep: assert property (@(posedge clk) disable iff (!nreset)
        valid_q |-> ($countones(eom_q) <= $countones(keep_q)));

    eomOnLenOrData: assert property (@(posedge clk) disable iff (!nreset)
        eomTypeBad == '0);
endmodule

// File: tb/tb_mold_msg_splitter.sv
// Bench for mold_msg_splitter: packets are built as lists of messages, so every
// byte's tag and every count is known from construction, then sliced into random beats.
module tb_mold_msg_splitter;
    localparam int D_W   = 8;
    localparam int D_LW  = 4;
    localparam int LEN_W = 16;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic nreset;

    always #5 clk = ~clk;

    mold_msg_splitter_if #(.D_W(D_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) busIf ();

    mold_msg_splitter #(.D_W(D_W), .D_LW(D_LW), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (busIf)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] expLen;
    logic [15:0] expCnt;
    logic        expErr;
    logic [63:0] expData;
    logic [7:0]  expKeep;

    logic [7:0]  pktByte[$];
    logic [1:0]  pktType[$];
    bit          pktEom[$];
    logic [15:0] pktField[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic l,
                                 input logic [63:0] d, input logic [7:0] k);
        @(negedge clk);
        busIf.valid_i = v;
        busIf.start_i = s;
        busIf.last_i  = l;
        busIf.data_i  = d;
        busIf.keep_i  = k;
        @(posedge clk);
        #1;
    endtask

    task automatic checkBeat(input string tag, input logic v, input logic [15:0] ty,
                             input logic [7:0] eom, input logic lenV, input logic cntV);
        checkOutput({tag, ".valid"},   64'(busIf.valid_o),     64'(v));
        checkOutput({tag, ".data"},    busIf.data_o,           expData);
        checkOutput({tag, ".keep"},    64'(busIf.keep_o),      64'(expKeep));
        checkOutput({tag, ".type"},    64'(busIf.lane_type_o), 64'(ty));
        checkOutput({tag, ".eom"},     64'(busIf.eom_o),       64'(eom));
        checkOutput({tag, ".len_v"},   64'(busIf.len_v_o),     64'(lenV));
        checkOutput({tag, ".len"},     64'(busIf.len_o),       64'(expLen));
        checkOutput({tag, ".cnt_v"},   64'(busIf.cnt_v_o),     64'(cntV));
        checkOutput({tag, ".msg_cnt"}, 64'(busIf.msg_cnt_o),   64'(expCnt));
        checkOutput({tag, ".err"},     64'(busIf.err_o),       64'(expErr));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, 8'($urandom));
        checkBeat("idle", 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
    endtask

    task automatic pushByte(input logic [7:0] b, input logic [1:0] t, input bit e, input logic [15:0] f);
        pktByte.push_back(b);
        pktType.push_back(t);
        pktEom.push_back(e);
        pktField.push_back(f);
    endtask

    // A packet is a list of messages serialised as length-prefixed blocks.
    task automatic buildPacket(input int numMsgs, input bit truncate, output bit truncErr);
        int sel;
        int msgLen;
        int cut;
        logic [15:0] len16;
        pktByte.delete();
        pktType.delete();
        pktEom.delete();
        pktField.delete();
        for (int m = 0; m < numMsgs; m++) begin
            sel = $urandom_range(0, 7);
            if (sel < 2)       msgLen = 0;
            else if (sel == 7) msgLen = $urandom_range(256, 280);
            else               msgLen = $urandom_range(1, 20);
            len16 = 16'(msgLen);
            pushByte(len16[15:8], 2'd1, 1'b0, 16'h0);
            pushByte(len16[7:0], 2'd2, msgLen == 0, len16);
            for (int i = 0; i < msgLen; i++) begin
                pushByte(8'($urandom), 2'd3, i == msgLen - 1, 16'h0);
            end
        end
        truncErr = 1'b0;
        if (truncate) begin
            cut = $urandom_range(1, pktByte.size() - 1);
            truncErr = !pktEom[cut-1];
            while (pktByte.size() > cut) begin
                void'(pktByte.pop_back());
                void'(pktType.pop_back());
                void'(pktEom.pop_back());
                void'(pktField.pop_back());
            end
        end
    endtask

    task automatic sendPacket(input bit truncErr, input int abortAfter);
        int idx;
        int n;
        int beats;
        logic [63:0] d;
        logic [7:0]  k;
        logic [15:0] ty;
        logic [7:0]  eom;
        logic        lenV;
        bit          first;
        bit          last;
        idx   = 0;
        beats = 0;
        while (idx < pktByte.size()) begin
            n = $urandom_range(1, D_W);
            if (n > pktByte.size() - idx) n = pktByte.size() - idx;
            d     = {$urandom, $urandom};
            k     = 8'((1 << n) - 1);
            ty    = '0;
            eom   = '0;
            lenV  = 1'b0;
            first = (idx == 0);
            last  = (idx + n == pktByte.size());
            if (first) begin
                expCnt = '0;
                expErr = 1'b0;
            end
            for (int j = 0; j < n; j++) begin
                d[8*j +: 8]  = pktByte[idx+j];
                ty[2*j +: 2] = pktType[idx+j];
                if (pktEom[idx+j]) begin
                    eom[j] = 1'b1;
                    expCnt = expCnt + 16'd1;
                end
                if (pktType[idx+j] == 2'd2) begin
                    lenV   = 1'b1;
                    expLen = pktField[idx+j];
                end
            end
            if (last && truncErr) expErr = 1'b1;
            expData = d;
            expKeep = k;
            applyStimulus(1'b1, first, last, d, k);
            checkBeat("beat", 1'b1, ty, eom, lenV, last);
            idx += n;
            beats++;
            if (abortAfter != 0 && beats >= abortAfter && !last) return;
            if ($urandom_range(0, 3) == 0) idleCycle();
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        nreset        = 1'b0;
        busIf.valid_i = 1'b0;
        #1;
        expLen  = '0;
        expCnt  = '0;
        expErr  = 1'b0;
        expData = '0;
        expKeep = '0;
        checkBeat("reset", 1'b0, 16'h0, 8'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        bit truncErr;
        nreset        = 1'b0;
        busIf.valid_i = 1'b0;
        busIf.start_i = 1'b0;
        busIf.last_i  = 1'b0;
        busIf.data_i  = '0;
        busIf.keep_i  = '0;
        resetDut();

        // Two messages in one beat: lengths 3 and 1.
        expData = 64'hDD01_00CC_BBAA_0300; expKeep = 8'hFF;
        expLen = 16'h0001; expCnt = 16'd2; expErr = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, expData, expKeep);
        checkBeat("single", 1'b1, 16'hE7F9, 8'h90, 1'b1, 1'b1);

        // Length 0x0010 with only six body bytes before last.
        expData = 64'h0605_0403_0201_1000; expKeep = 8'hFF;
        expLen = 16'h0010; expCnt = 16'd0; expErr = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, expData, expKeep);
        checkBeat("trunc", 1'b1, 16'hFFF9, 8'h00, 1'b1, 1'b1);
        idleCycle();

        // Four zero-length messages; the start also clears the earlier error.
        expData = 64'h0; expKeep = 8'hFF;
        expLen = 16'h0000; expCnt = 16'd4; expErr = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, expData, expKeep);
        checkBeat("zero", 1'b1, 16'h9999, 8'hAA, 1'b1, 1'b1);

        // Partial keep: three valid lanes carrying a one-byte message.
        expData = 64'h5A5A_5A5A_5AEE_0100; expKeep = 8'h07;
        expLen = 16'h0001; expCnt = 16'd1; expErr = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, expData, expKeep);
        checkBeat("partial", 1'b1, 16'h0039, 8'h04, 1'b1, 1'b1);

        for (int p = 0; p < 60; p++) begin
            buildPacket($urandom_range(1, 5), $urandom_range(0, 3) == 0, truncErr);
            if ($urandom_range(0, 7) == 0) begin
                sendPacket(truncErr, 1);
                resetDut();
            end else begin
                sendPacket(truncErr, 0);
            end
        end
        idleCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
